// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU issue queue and the pipeline_ALU bench drivers.
// Packed instruction word: {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
package alu_pkg;

  localparam int INSTR_W   = 24;
  localparam int REG_IDX_W = 4;
  localparam int ADDR_W    = 8;
  localparam int FUNC_W    = 4;

  localparam int FUNC_LSB  = 20;
  localparam int RD_LSB    = 16;
  localparam int RS1_LSB   = 12;
  localparam int RS2_LSB   = 8;
  localparam int ADDR_LSB  = 0;

  typedef struct packed {
    logic [FUNC_W-1:0]    func;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rs1;
    logic [REG_IDX_W-1:0] rs2;
    logic [ADDR_W-1:0]    addr;
  } instr_t;

  // One scoreboard slot: destination of an op issued some cycles ago.
  typedef struct packed {
    logic                 v;
    logic [REG_IDX_W-1:0] rd;
  } sb_entry_t;

  function automatic instr_t make_instr(input logic [FUNC_W-1:0] func,
                                        input logic [REG_IDX_W-1:0] rd,
                                        input logic [REG_IDX_W-1:0] rs1,
                                        input logic [REG_IDX_W-1:0] rs2,
                                        input logic [ADDR_W-1:0] addr);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[FUNC_LSB +: FUNC_W]    = func;
    w[RD_LSB   +: REG_IDX_W] = rd;
    w[RS1_LSB  +: REG_IDX_W] = rs1;
    w[RS2_LSB  +: REG_IDX_W] = rs2;
    w[ADDR_LSB +: ADDR_W]    = addr;
    return instr_t'(w);
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Instruction push side and issue side of the ALU issue queue.
// slave = the queue, master = the producer/consumer driving it.
interface alu_issue_queue_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  instr_t               in_instr;
  logic                 issue_vld;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic [REG_IDX_W-1:0] rd;
  logic [FUNC_W-1:0]    func;
  logic [ADDR_W-1:0]    addr;

  modport master (
    output in_valid, in_instr,
    input  in_ready, issue_vld, rs1, rs2, rd, func, addr
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, issue_vld, rs1, rs2, rd, func, addr
  );

endinterface

// File: rtl/alu_issue_queue_fifo.sv
// DEPTH-entry instruction FIFO with occupancy count; head is read combinationally.
// Pointers wrap modulo DEPTH (DEPTH is a power of two). No write-through bypass.
module issue_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  instr_t           din,
  output instr_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  instr_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk1) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// In-order ALU issue queue: buffers instructions and issues at most one per clock,
// bubbling the head while one of its sources matches an rd issued within the
// last HAZ_WIN cycles. Optional ISSUE_STATS_EN adds saturating issue/stall counters.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int HAZ_WIN = 2
) (
  input  logic                   clk1,
  input  logic                   rst,
  alu_issue_queue_if.slave       bus,
  input  logic                   issue_en,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
`ifdef ISSUE_STATS_EN
  ,
  output logic [15:0]            stat_issued,
  output logic [15:0]            stat_stall
`endif
);

  instr_t    head;
  logic      full;
  logic      empty;
  logic      push;
  logic      issue;
  logic      hazard;
  sb_entry_t sb [HAZ_WIN];

  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full && !flush;
  assign issue        = !empty && issue_en && !hazard && !flush;

  issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk1  (clk1),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (issue),
    .din   (bus.in_instr),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // RAW check of the head sources against every pending destination; rd-only match is allowed.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < HAZ_WIN; i++) begin
      if (sb[i].v && ((sb[i].rd == head.rs1) || (sb[i].rd == head.rs2))) hazard = 1'b1;
    end
  end

  // Scoreboard shifts every cycle, including bubbles, so pending entries age out.
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < HAZ_WIN; i++) sb[i] <= '0;
    end else begin
      sb[0] <= {issue, head.rd};
      for (int unsigned i = 1; i < HAZ_WIN; i++) sb[i] <= sb[i-1];
    end
  end

  // Issue registers: fields load only on issue and otherwise hold their last value.
  always_ff @(posedge clk1) begin
    if (rst) begin
      bus.issue_vld <= 1'b0;
      bus.rs1       <= '0;
      bus.rs2       <= '0;
      bus.rd        <= '0;
      bus.func      <= '0;
      bus.addr      <= '0;
    end else begin
      bus.issue_vld <= issue;
      if (issue) begin
        bus.rs1  <= head.rs1;
        bus.rs2  <= head.rs2;
        bus.rd   <= head.rd;
        bus.func <= head.func;
        bus.addr <= head.addr;
      end
    end
  end

`ifdef ISSUE_STATS_EN
  // Saturating counts of issued instructions and hazard-stalled cycles.
  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue && (stat_issued != '1)) stat_issued <= stat_issued + 1'b1;
      if (!empty && issue_en && hazard && (stat_stall != '1)) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: a per-cycle vector table plus hand-written
// sequences for mid-traffic reset, full queue and (with ISSUE_STATS_EN) the counters.
module tb_alu_issue_queue;
  import alu_pkg::*;

  logic       clk1 = 1'b0;
  logic       rst;
  logic       issue_en;
  logic       flush;
  logic [3:0] count;
`ifdef ISSUE_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_stall;
`endif

  int errors = 0;
  int checks = 0;

  alu_issue_queue_if bus ();

  alu_issue_queue #(.DEPTH(8), .HAZ_WIN(2)) dut (
    .clk1     (clk1),
    .rst      (rst),
    .bus      (bus),
    .issue_en (issue_en),
    .flush    (flush),
    .count    (count)
`ifdef ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic   r, v, en, fl;
    instr_t ins;
    logic   e_vld, e_rdy;
    int     e_cnt;
    instr_t e_out;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input logic r, v, en, fl, input instr_t ins,
                              input logic e_vld, e_rdy, input int e_cnt, input instr_t e_out);
    vec_t t;
    t.r = r; t.v = v; t.en = en; t.fl = fl; t.ins = ins;
    t.e_vld = e_vld; t.e_rdy = e_rdy; t.e_cnt = e_cnt; t.e_out = e_out;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive inputs mid-cycle, then sample just after the following rising edge.
  task automatic cyc(input logic r, v, en, fl, input instr_t ins);
    @(negedge clk1);
    rst = r; bus.in_valid = v; issue_en = en; flush = fl; bus.in_instr = ins;
    @(posedge clk1);
    #1;
  endtask

  task automatic check_out(input string name, input logic e_vld, e_rdy, input int e_cnt,
                           input instr_t e_out);
    instr_t got;
    got = {bus.func, bus.rd, bus.rs1, bus.rs2, bus.addr};
    check({name, ".vld"},   32'(bus.issue_vld), 32'(e_vld));
    check({name, ".rdy"},   32'(bus.in_ready),  32'(e_rdy));
    check({name, ".cnt"},   32'(count),         32'(e_cnt));
    check({name, ".out"},   32'(got),           32'(e_out));
  endtask

  initial begin
    instr_t A, M, S, X, Y, N, Z;
    instr_t F [9];

    A = make_instr(4'h1, 4'd10, 4'd3,  4'd5,  8'h10); // ADD r3,r5 -> r10
    M = make_instr(4'h3, 4'd12, 4'd3,  4'd8,  8'h20); // MUL r3,r8 -> r12
    S = make_instr(4'h2, 4'd14, 4'd10, 4'd5,  8'h30); // SUB r10,r5 -> r14 (RAW on A)
    X = make_instr(4'h1, 4'd14, 4'd1,  4'd2,  8'h40); // rd matches S only (WAW)
    Y = make_instr(4'h2, 4'd3,  4'd0,  4'd14, 8'h50); // rs2 RAW on X
    N = '0;
    Z = make_instr(4'hF, 4'd15, 4'd15, 4'd15, 8'hFF);
    for (int k = 0; k < 9; k++) F[k] = make_instr(4'h1, 4'(k + 1), 4'd0, 4'd0, 8'(k));

    rst = 1'b1; bus.in_valid = 1'b0; issue_en = 1'b0; flush = 1'b0; bus.in_instr = '0;

    //            r  v  en fl ins   vld rdy cnt out
    tbl[0]  = mk(1, 0, 1, 0, N,    0,  1,  0,  N);
    tbl[1]  = mk(1, 0, 1, 0, N,    0,  1,  0,  N);
    tbl[2]  = mk(0, 1, 1, 0, A,    0,  1,  1,  N);  // no bypass
    tbl[3]  = mk(0, 1, 1, 0, M,    1,  1,  1,  A);  // push+pop, count held
    tbl[4]  = mk(0, 0, 1, 0, N,    1,  1,  0,  M);  // independent: no bubble
    tbl[5]  = mk(0, 0, 1, 0, N,    0,  1,  0,  M);
    tbl[6]  = mk(0, 0, 1, 0, N,    0,  1,  0,  M);
    tbl[7]  = mk(0, 1, 1, 0, A,    0,  1,  1,  M);
    tbl[8]  = mk(0, 1, 1, 0, S,    1,  1,  1,  A);
    tbl[9]  = mk(0, 0, 1, 0, N,    0,  1,  1,  A);  // bubble 1
    tbl[10] = mk(0, 0, 1, 0, N,    0,  1,  1,  A);  // bubble 2
    tbl[11] = mk(0, 0, 1, 0, N,    1,  1,  0,  S);
    tbl[12] = mk(0, 1, 1, 0, X,    0,  1,  1,  S);
    tbl[13] = mk(0, 1, 1, 0, Y,    1,  1,  1,  X);  // rd-only match issues
    tbl[14] = mk(0, 0, 1, 0, N,    0,  1,  1,  X);  // rs2 hazard
    tbl[15] = mk(0, 0, 1, 0, N,    0,  1,  1,  X);
    tbl[16] = mk(0, 0, 1, 0, N,    1,  1,  0,  Y);
    tbl[17] = mk(0, 1, 0, 0, A,    0,  1,  1,  Y);  // external stall
    tbl[18] = mk(0, 0, 0, 0, N,    0,  1,  1,  Y);
    tbl[19] = mk(0, 0, 1, 0, N,    1,  1,  0,  A);
    tbl[20] = mk(0, 1, 0, 0, A,    0,  1,  1,  A);
    tbl[21] = mk(0, 1, 0, 0, M,    0,  1,  2,  A);
    tbl[22] = mk(0, 1, 0, 0, S,    0,  1,  3,  A);
    tbl[23] = mk(0, 1, 0, 0, X,    0,  1,  4,  A);
    tbl[24] = mk(0, 1, 0, 0, Y,    0,  1,  5,  A);
    tbl[25] = mk(0, 1, 1, 1, M,    0,  1,  0,  A);  // flush drops concurrent push
    tbl[26] = mk(0, 0, 1, 0, N,    0,  1,  0,  A);
    tbl[27] = mk(0, 0, 1, 0, N,    0,  1,  0,  A);

    for (int i = 0; i < 28; i++) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].en, tbl[i].fl, tbl[i].ins);
      check_out($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_rdy, tbl[i].e_cnt, tbl[i].e_out);
    end

    // Reset asserted for two cycles in the middle of traffic.
    cyc(0, 1, 1, 0, A);
    cyc(0, 1, 1, 0, M);
    check_out("pre_rst", 1'b1, 1'b1, 1, A);
    cyc(1, 1, 1, 0, S);
    cyc(1, 1, 1, 0, S);
    check_out("mid_rst", 1'b0, 1'b1, 0, N);
    cyc(0, 1, 1, 0, S);
    check_out("post_rst_push", 1'b0, 1'b1, 1, N);
    cyc(0, 0, 1, 0, N);
    check_out("post_rst_issue", 1'b1, 1'b1, 0, S);

    // Fill with issue disabled: 9th push dropped, then drain in order.
    cyc(1, 0, 0, 0, N);
    for (int k = 0; k < 9; k++) begin
      cyc(0, 1, 0, 0, F[k]);
      check_out($sformatf("fill%0d", k), 1'b0, (k + 1 < 8), (k + 1 < 8) ? k + 1 : 8, N);
    end
    cyc(0, 1, 1, 0, Z);  // pop while full; push still refused this cycle
    check_out("drain0", 1'b1, 1'b1, 7, F[0]);
    for (int j = 1; j < 8; j++) begin
      cyc(0, 0, 1, 0, N);
      check_out($sformatf("drain%0d", j), 1'b1, 1'b1, 7 - j, F[j]);
    end
    cyc(0, 0, 1, 0, N);
    check_out("drain_end", 1'b0, 1'b1, 0, F[7]);

`ifdef ISSUE_STATS_EN
    cyc(1, 0, 1, 0, N);
    check("stat_issued_rst", 32'(stat_issued), 32'd0);
    cyc(0, 1, 1, 0, A);
    cyc(0, 1, 1, 0, S);
    for (int j = 0; j < 4; j++) cyc(0, 0, 1, 0, N);
    check("stat_issued", 32'(stat_issued), 32'd2);
    check("stat_stall",  32'(stat_stall),  32'd2);
    cyc(0, 0, 1, 1, N);
    check("stat_issued_flush", 32'(stat_issued), 32'd0);
    check("stat_stall_flush",  32'(stat_stall),  32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
